// File: rtl/usb_kbd_event_decoder_if.sv
// Purpose : bundles the report intake, event output and status/control wires of usb_kbd_event_decoder.
// Latency : none; this is wiring only.
// Backpr. : the event stream uses valid/ready (event_valid_o / event_ready_i); report intake has no backpressure.
//
// Ports (signals):
//   report_i[63:0], report_valid_i : boot report and its one-cycle strobe (HID host -> decoder)
//   event_o[8:0], event_valid_o    : FIFO head {press, usage} and not-empty flag (decoder -> SoC)
//   event_ready_i                  : pops the head (SoC -> decoder)
//   busy_o, report_drop_o          : diff engine active / sticky pending-overwrite flag (decoder -> SoC)
//   clear_i                        : clears report_drop_o (SoC -> decoder)
// Modports: master = host/SoC side, slave = decoder side.
interface usb_kbd_event_decoder_if;
    logic [63:0] report_i;
    logic        report_valid_i;
    logic [8:0]  event_o;
    logic        event_valid_o;
    logic        event_ready_i;
    logic        busy_o;
    logic        report_drop_o;
    logic        clear_i;

    modport master (
        output report_i, report_valid_i, event_ready_i, clear_i,
        input  event_o, event_valid_o, busy_o, report_drop_o
    );

    modport slave (
        input  report_i, report_valid_i, event_ready_i, clear_i,
        output event_o, event_valid_o, busy_o, report_drop_o
    );
endinterface

// File: rtl/usb_kbd_event_decoder.sv
// Purpose : generic first-word-fall-through FIFO used for the key event queue.
// Latency : a pushed word is visible at the output in the cycle after the push edge.
// Backpr. : in_rdy low when full (push waits even if a pop happens that cycle); pop while empty is ignored.
//
// Ports: clk, rst_n (async active-low); in_vld/in_dat/in_rdy push side; out_vld/out_dat/out_rdy pop side.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             in_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Fullness is judged on the current count, so a pop in the same cycle
    // does not make room for a push until the next cycle.
    assign in_rdy  = (count != FULL_CNT);
    assign out_vld = (count != '0);
    assign out_dat = out_vld ? mem[rd_ptr] : '0;
    assign do_push = in_vld && in_rdy;
    assign do_pop  = out_rdy && out_vld;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointers are AW bits wide with DEPTH a power of two, so they wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Purpose : diffs USB HID boot keyboard reports against the last committed one and queues press/release events.
// Latency : 21 cycles per report (8 modifier + 6 release + 6 press steps + commit) plus FIFO-full stall cycles.
// Backpr. : a step that must emit holds while the event FIFO is full; one extra report is buffered, later ones overwrite it.
//
// Ports: clk, reset_n (async active-low); bus (slave modport): report_i/report_valid_i in,
//        event_o/event_valid_o/event_ready_i event stream, busy_o, report_drop_o, clear_i.
module usb_kbd_event_decoder #(
    parameter int         FIFO_DEPTH    = 16,
    parameter logic [7:0] ROLLOVER_CODE = 8'h01
) (
    input  logic                    clk,
    input  logic                    reset_n,
    usb_kbd_event_decoder_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_MODS,
        S_REL,
        S_PRESS,
        S_COMMIT
    } state_t;

    // Layout matches the boot report: slot s sits at [23+8s:16+8s].
    typedef struct packed {
        logic [5:0][7:0] slot;
        logic [7:0]      rsvd;
        logic [7:0]      mod;
    } kbd_rpt_t;

    state_t          state;
    logic [2:0]      idx;
    logic [7:0]      cur_mod;
    logic [7:0]      prev_mod;
    logic [5:0][7:0] cur_slot;
    logic [5:0][7:0] prev_slot;
    kbd_rpt_t        pend;
    logic            pend_v;
    logic            busy_q;
    logic            drop_q;

    kbd_rpt_t        rpt_in;
    kbd_rpt_t        cand;
    logic            cand_vld;
    logic            cand_rollover;
    logic            emit_need;
    logic [8:0]      emit_dat;
    logic            last_step;
    logic            hit;
    logic            step_adv;
    logic            fifo_in_rdy;

    assign rpt_in = kbd_rpt_t'(bus.report_i);

    // In IDLE the buffered report takes precedence over a fresh strobe.
    assign cand     = pend_v ? pend : rpt_in;
    assign cand_vld = pend_v || bus.report_valid_i;

    always_comb begin
        cand_rollover = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (cand.slot[k] != ROLLOVER_CODE) begin
                cand_rollover = 1'b0;
            end
        end
    end

    // Per-step diff: decides whether the current step emits and what.
    always_comb begin
        emit_need = 1'b0;
        emit_dat  = '0;
        last_step = 1'b0;
        hit       = 1'b0;
        case (state)
            S_MODS: begin
                emit_need = (cur_mod[idx] != prev_mod[idx]);
                emit_dat  = {cur_mod[idx], 8'hE0 | {5'd0, idx}};
                last_step = (idx == 3'd7);
            end
            S_REL: begin
                for (int k = 0; k < 6; k++) begin
                    if (cur_slot[k] == prev_slot[idx]) begin
                        hit = 1'b1;
                    end
                end
                emit_need = (prev_slot[idx] != 8'h00) && !hit;
                emit_dat  = {1'b0, prev_slot[idx]};
                last_step = (idx == 3'd5);
            end
            S_PRESS: begin
                // A usage repeated in earlier slots of the same report is pressed only once.
                for (int k = 0; k < 6; k++) begin
                    if (prev_slot[k] == cur_slot[idx]) begin
                        hit = 1'b1;
                    end
                    if ((3'(k) < idx) && (cur_slot[k] == cur_slot[idx])) begin
                        hit = 1'b1;
                    end
                end
                emit_need = (cur_slot[idx] != 8'h00) && !hit;
                emit_dat  = {1'b1, cur_slot[idx]};
                last_step = (idx == 3'd5);
            end
            default: begin
            end
        endcase
    end

    // Non-emitting steps never wait on the FIFO.
    assign step_adv = !emit_need || fifo_in_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            cur_mod   <= '0;
            prev_mod  <= '0;
            cur_slot  <= '0;
            prev_slot <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            if (bus.clear_i) begin
                drop_q <= 1'b0;
            end

            // Intake: in IDLE a buffered report moves to cur and a same-cycle
            // strobe refills the buffer; while busy every strobe lands in the
            // buffer, flagging a drop if it still held an unprocessed report.
            if (state == S_IDLE) begin
                if (pend_v) begin
                    pend_v <= bus.report_valid_i;
                    if (bus.report_valid_i) begin
                        pend <= rpt_in;
                    end
                end
            end else if (bus.report_valid_i) begin
                pend   <= rpt_in;
                pend_v <= 1'b1;
                if (pend_v) begin
                    drop_q <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    // Rollover reports are consumed without touching prev.
                    if (cand_vld && !cand_rollover) begin
                        cur_mod  <= cand.mod;
                        cur_slot <= cand.slot;
                        idx      <= '0;
                        state    <= S_MODS;
                        busy_q   <= 1'b1;
                    end
                end
                S_MODS: begin
                    if (step_adv) begin
                        if (last_step) begin
                            idx   <= '0;
                            state <= S_REL;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                S_REL: begin
                    if (step_adv) begin
                        if (last_step) begin
                            idx   <= '0;
                            state <= S_PRESS;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                S_PRESS: begin
                    if (step_adv) begin
                        if (last_step) begin
                            idx   <= '0;
                            state <= S_COMMIT;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                S_COMMIT: begin
                    prev_mod  <= cur_mod;
                    prev_slot <= cur_slot;
                    state     <= S_IDLE;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .in_vld  (emit_need),
        .in_dat  (emit_dat),
        .in_rdy  (fifo_in_rdy),
        .out_vld (bus.event_valid_o),
        .out_dat (bus.event_o),
        .out_rdy (bus.event_ready_i)
    );

    assign bus.busy_o        = busy_q;
    assign bus.report_drop_o = drop_q;
endmodule

// File: tb/tb_usb_kbd_event_decoder.sv
// Purpose : directed self-checking bench for usb_kbd_event_decoder (timing, diffing, rollover, stall, drop, reset).
// Latency : n/a.
// Backpr. : event_ready_i is held low in stall scenarios and high otherwise.
module tb_usb_kbd_event_decoder;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    usb_kbd_event_decoder_if bus ();

    usb_kbd_event_decoder #(
        .FIFO_DEPTH    (16),
        .ROLLOVER_CODE (8'h01)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every event that is popped (valid && ready across the next edge).
    always @(negedge clk) begin
        if (reset_n && bus.event_valid_o && bus.event_ready_i) begin
            got_q.push_back(bus.event_o);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] m,
                                       input logic [7:0] s0, input logic [7:0] s1,
                                       input logic [7:0] s2, input logic [7:0] s3,
                                       input logic [7:0] s4, input logic [7:0] s5);
        return {s5, s4, s3, s2, s1, s0, 8'h00, m};
    endfunction

    // One-cycle strobe; returns 1 time unit after the strobe edge (edge N).
    task automatic send(input logic [63:0] r);
        @(posedge clk);
        #1;
        bus.report_i       = r;
        bus.report_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.report_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int stable;
        stable = 0;
        for (int c = 0; c < 400 && stable < 3; c++) begin
            @(negedge clk);
            if (!bus.busy_o && !bus.event_valid_o) stable++;
            else stable = 0;
        end
        check_eq({tag, "_idle"}, stable, 3);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check_eq({tag, "_cnt"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("%s_ev%0d", tag, k), {23'd0, got_q[k]}, {23'd0, exp_q[k]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_vld;
        int busy_fall;
        n_checks           = 0;
        n_errors           = 0;
        reset_n            = 1'b0;
        bus.report_i       = '0;
        bus.report_valid_i = 1'b0;
        bus.event_ready_i  = 1'b0;
        bus.clear_i        = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_valid", bus.event_valid_o, 0);
        check_eq("rst_event", bus.event_o, 0);
        check_eq("rst_busy", bus.busy_o, 0);
        check_eq("rst_drop", bus.report_drop_o, 0);

        // Single press: timing of first event and busy fall
        send(mk(8'h00, 8'h04, 0, 0, 0, 0, 0));
        first_vld = -1;
        busy_fall = -1;
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            if (j == 1) check_eq("busy_after_N", bus.busy_o, 1);
            if (first_vld < 0 && bus.event_valid_o) first_vld = j - 1;
            if (busy_fall < 0 && !bus.busy_o) busy_fall = j - 1;
        end
        check_eq("first_event_edge", first_vld, 15);
        check_eq("busy_fall_edge", busy_fall, 21);
        @(posedge clk); #1; bus.event_ready_i = 1'b1;
        wait_idle("press_a");
        exp_q.push_back(9'h104);
        compare_events("press_a");

        // Release
        send(mk(8'h00, 0, 0, 0, 0, 0, 0));
        wait_idle("rel_a");
        exp_q.push_back(9'h004);
        compare_events("rel_a");

        // Modifier plus keys
        send(mk(8'h02, 8'h05, 8'h06, 0, 0, 0, 0));
        wait_idle("mod1");
        exp_q.push_back(9'h1E1); exp_q.push_back(9'h105); exp_q.push_back(9'h106);
        compare_events("mod1");
        send(mk(8'h00, 8'h06, 8'h07, 0, 0, 0, 0));
        wait_idle("mod2");
        exp_q.push_back(9'h0E1); exp_q.push_back(9'h005); exp_q.push_back(9'h107);
        compare_events("mod2");

        // Rollover is discarded: no events, prev stays {06,07}
        send(mk(8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01));
        wait_idle("rollover");
        compare_events("rollover");
        check_eq("rollover_busy", bus.busy_o, 0);

        // Duplicate slots: one press; releases prove prev was untouched
        send(mk(8'h00, 8'h09, 8'h09, 0, 0, 0, 0));
        wait_idle("dup");
        exp_q.push_back(9'h006); exp_q.push_back(9'h007); exp_q.push_back(9'h109);
        compare_events("dup");
        send(mk(8'h00, 8'h09, 0, 0, 0, 0, 0));
        wait_idle("dup_keep");
        compare_events("dup_keep");
        send(mk(8'h00, 0, 0, 0, 0, 0, 0));
        wait_idle("dup_rel");
        exp_q.push_back(9'h009);
        compare_events("dup_rel");

        // Back-pressure: 14 + 20 events into a 16-entry FIFO with no pops
        @(posedge clk); #1; bus.event_ready_i = 1'b0;
        send(mk(8'hFF, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A));
        send(mk(8'h00, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10));
        repeat (80) @(negedge clk);
        check_eq("stall_busy", bus.busy_o, 1);
        check_eq("stall_valid", bus.event_valid_o, 1);
        check_eq("stall_head", bus.event_o, 9'h1E0);
        check_eq("stall_nodrop", bus.report_drop_o, 0);
        @(posedge clk); #1; bus.event_ready_i = 1'b1;
        wait_idle("bp");
        for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, 8'hE0 + 8'(k)});
        exp_q.push_back(9'h104); exp_q.push_back(9'h105); exp_q.push_back(9'h106);
        exp_q.push_back(9'h107); exp_q.push_back(9'h108); exp_q.push_back(9'h10A);
        for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, 8'hE0 + 8'(k)});
        exp_q.push_back(9'h004); exp_q.push_back(9'h005); exp_q.push_back(9'h006);
        exp_q.push_back(9'h007); exp_q.push_back(9'h008); exp_q.push_back(9'h00A);
        for (int k = 0; k < 6; k++) exp_q.push_back({1'b1, 8'h0B + 8'(k)});
        compare_events("bp");

        // Pending/drop: three back-to-back strobes, the middle one is lost
        @(posedge clk); #1;
        bus.report_i = mk(8'h00, 8'h20, 0, 0, 0, 0, 0); bus.report_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.report_i = mk(8'h00, 8'h21, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        bus.report_i = mk(8'h00, 8'h22, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_eq("drop_before", bus.report_drop_o, 0);
        @(posedge clk); #1;
        bus.report_valid_i = 1'b0;
        @(negedge clk);
        check_eq("drop_set", bus.report_drop_o, 1);
        wait_idle("pend");
        for (int k = 0; k < 6; k++) exp_q.push_back({1'b0, 8'h0B + 8'(k)});
        exp_q.push_back(9'h120); exp_q.push_back(9'h020); exp_q.push_back(9'h122);
        compare_events("pend");
        check_eq("drop_sticky", bus.report_drop_o, 1);
        @(posedge clk); #1; bus.clear_i = 1'b1;
        @(posedge clk); #1; bus.clear_i = 1'b0;
        @(negedge clk);
        check_eq("drop_clear", bus.report_drop_o, 0);

        // Async reset during PRESS with 4 events queued
        @(posedge clk); #1; bus.event_ready_i = 1'b0;
        send(mk(8'h00, 8'h30, 8'h31, 8'h32, 8'h33, 0, 0));
        repeat (18) @(negedge clk);
        check_eq("pre_rst_busy", bus.busy_o, 1);
        check_eq("pre_rst_head", bus.event_o, 9'h022);
        #1; reset_n = 1'b0;
        #1;
        check_eq("arst_valid", bus.event_valid_o, 0);
        check_eq("arst_event", bus.event_o, 0);
        check_eq("arst_busy", bus.busy_o, 0);
        check_eq("arst_drop", bus.report_drop_o, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1; bus.event_ready_i = 1'b1;
        @(negedge clk);
        check_eq("post_rst_empty", bus.event_valid_o, 0);
        send(mk(8'h00, 8'h04, 0, 0, 0, 0, 0));
        wait_idle("post_rst");
        exp_q.push_back(9'h104);
        compare_events("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
